ras_stack: RTL and testbench

Return address stack for the fetch unit, directly downstream of the branch target buffer. On each valid fetch bundle it consumes the BTB's 2-bit RAS control, the bundle PC and the branch position. It pushes the call return address, pops for returns, or does both for coroutine jumps, and presents the predicted return target combinationally. A flush port restores the speculative pointer and occupancy from a checkpoint on redirect.

---
 rtl/ras_stack.sv | 68 ++++++
 tb/tb_ras_stack.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ras_stack.sv
// ras_stack: return address stack with push/pop/coroutine ops and checkpoint flush restore
module ras_stack #(
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ctl_valid_i,
  input  logic [1:0]    ras_ctl_i,
  input  logic [63:0]   bundle_pc_i,
  input  logic [2:0]    br_pos_i,
  input  logic          flush_i,
  input  logic [PW-1:0] flush_tos_i,
  input  logic [PW:0]   flush_cnt_i,
  output logic [63:0]   ras_top_o,
  output logic          ras_valid_o,
  output logic [PW-1:0] ras_tos_o,
  output logic [PW:0]   ras_cnt_o,
  output logic          ras_ovf_o
);
  localparam logic [PW:0] full_cnt = (PW+1)'(DEPTH);
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] tos;
  logic [PW-1:0] tos_inc;
  logic [PW-1:0] tos_dec;
  logic [PW:0]   cnt;
  logic [1:0]    op;
  logic [63:0]   ra;
  logic          full;
  logic          empty;
  always_comb begin
    op      = (ctl_valid_i && !flush_i) ? ras_ctl_i : 2'b00;
    // slot 7 carries out of the 5-bit bundle offset into the next bundle base
    ra      = {bundle_pc_i[63:5], 5'b0} + 64'({br_pos_i, 2'b00}) + 64'd4;
    tos_inc = tos + 1'b1;
    tos_dec = tos - 1'b1;
    full    = cnt == full_cnt;
    empty   = cnt == '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      tos       <= '0;
      cnt       <= '0;
      ras_ovf_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ras_ovf_o <= (op == 2'b01) && full;
      if (flush_i) begin
        tos <= flush_tos_i;
        cnt <= (flush_cnt_i > full_cnt) ? full_cnt : flush_cnt_i;
      end else if (op == 2'b01) begin
        tos          <= tos_inc;
        mem[tos_inc] <= ra;
        cnt          <= full ? cnt : cnt + 1'b1;
      end else if (op == 2'b10 && !empty) begin
        tos <= tos_dec;
        cnt <= cnt - 1'b1;
      end else if (op == 2'b11) begin
        mem[tos] <= ra;
        cnt      <= empty ? (PW+1)'(1) : cnt;
      end
    end
  end
  assign ras_top_o   = mem[tos];
  assign ras_valid_o = !empty;
  assign ras_tos_o   = tos;
  assign ras_cnt_o   = cnt;
endmodule

// File: tb/tb_ras_stack.sv
// tb_ras_stack: directed plus random checks of ras_stack against a behavioural stack model
module tb_ras_stack;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctl_valid_i = 1'b0;
  logic [1:0]  ras_ctl_i = 2'b00;
  logic [63:0] bundle_pc_i = '0;
  logic [2:0]  br_pos_i = '0;
  logic        flush_i = 1'b0;
  logic [3:0]  flush_tos_i = '0;
  logic [4:0]  flush_cnt_i = '0;
  logic [63:0] ras_top_o;
  logic        ras_valid_o;
  logic [3:0]  ras_tos_o;
  logic [4:0]  ras_cnt_o;
  logic        ras_ovf_o;
  int errors = 0;
  int checks = 0;
  logic [63:0] m_mem [16];
  int m_tos, m_cnt;
  bit m_ovf;

  ras_stack #(.DEPTH(16)) dut (
    .clock(clock), .reset(reset), .ctl_valid_i(ctl_valid_i), .ras_ctl_i(ras_ctl_i),
    .bundle_pc_i(bundle_pc_i), .br_pos_i(br_pos_i), .flush_i(flush_i),
    .flush_tos_i(flush_tos_i), .flush_cnt_i(flush_cnt_i), .ras_top_o(ras_top_o),
    .ras_valid_o(ras_valid_o), .ras_tos_o(ras_tos_o), .ras_cnt_o(ras_cnt_o),
    .ras_ovf_o(ras_ovf_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_tos = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  task automatic check_all();
    chk("top", ras_top_o, m_mem[m_tos]);
    chk("valid", 64'(ras_valid_o), 64'(m_cnt != 0));
    chk("tos", 64'(ras_tos_o), 64'(m_tos));
    chk("cnt", 64'(ras_cnt_o), 64'(m_cnt));
    chk("ovf", 64'(ras_ovf_o), 64'(m_ovf));
  endtask

  // one cycle: drive, check pre-edge outputs, clock, advance the model
  task automatic step(input bit r, input bit v, input logic [1:0] c, input logic [63:0] pc,
                      input logic [2:0] pos, input bit fl, input int ft, input int fc);
    logic [63:0] ra;
    reset = r; ctl_valid_i = v; ras_ctl_i = c; bundle_pc_i = pc; br_pos_i = pos;
    flush_i = fl; flush_tos_i = 4'(ft); flush_cnt_i = 5'(fc);
    #1 check_all();
    @(posedge clock);
    ra = (pc & ~64'h1F) + 64'(pos) * 4 + 4;
    if (r) model_reset();
    else begin
      m_ovf = 0;
      if (fl) begin
        m_tos = ft;
        m_cnt = (fc > 16) ? 16 : fc;
      end else if (v) begin
        if (c == 2'b01) begin
          m_ovf = (m_cnt == 16);
          m_tos = (m_tos + 1) % 16;
          m_mem[m_tos] = ra;
          if (m_cnt < 16) m_cnt++;
        end else if (c == 2'b10 && m_cnt > 0) begin
          m_tos = (m_tos + 15) % 16;
          m_cnt--;
        end else if (c == 2'b11) begin
          m_mem[m_tos] = ra;
          if (m_cnt == 0) m_cnt = 1;
        end
      end
    end
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic [2:0] pos);
    step(0, 1, 2'b01, pc, pos, 0, 0, 0);
  endtask

  task automatic pop();
    step(0, 1, 2'b10, 64'h0, 3'd0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    // push then pop
    push(64'h1000, 3'd2);
    chk("push_top", ras_top_o, 64'h100C);
    chk("push_cnt", 64'(ras_cnt_o), 64'd1);
    chk("push_tos", 64'(ras_tos_o), 64'd1);
    chk("push_valid", 64'(ras_valid_o), 64'd1);
    pop();
    chk("pop_cnt", 64'(ras_cnt_o), 64'd0);
    chk("pop_valid", 64'(ras_valid_o), 64'd0);
    // carry into bit 5
    push(64'h1FE4, 3'd7);
    chk("carry_top", ras_top_o, 64'h2000);
    pop();
    // overflow
    for (int i = 1; i <= 17; i++) begin
      push(64'(i) << 8, 3'd0);
      chk("ovf_pulse", 64'(ras_ovf_o), 64'(i == 17));
    end
    chk("ovf_cnt", 64'(ras_cnt_o), 64'd16);
    for (int i = 17; i >= 2; i--) begin
      #1 chk("ovf_pop_order", ras_top_o, (64'(i) << 8) + 4);
      pop();
    end
    chk("ovf_drained", 64'(ras_valid_o), 64'd0);
    pop();
    chk("underflow_valid", 64'(ras_valid_o), 64'd0);
    chk("underflow_ovf", 64'(ras_ovf_o), 64'd0);
    // coroutine
    push(64'h3000, 3'd0);
    push(64'h4000, 3'd0);
    push(64'h9FE0, 3'd7);
    chk("co_setup", ras_top_o, 64'hA000);
    step(0, 1, 2'b11, 64'hB000, 3'd0, 0, 0, 0);
    chk("co_top", ras_top_o, 64'hB004);
    chk("co_cnt", 64'(ras_cnt_o), 64'd3);
    for (int i = 0; i < 3; i++) pop();
    step(0, 1, 2'b11, 64'hC000, 3'd1, 0, 0, 0);
    chk("co_empty_cnt", 64'(ras_cnt_o), 64'd1);
    // flush restore with a dropped push
    step(1, 0, 2'b00, 64'h0, 3'd0, 0, 0, 0);
    push(64'h5000, 3'd0);
    push(64'h6000, 3'd0);
    for (int i = 0; i < 3; i++) push(64'h7000 + 64'(i) * 64'h100, 3'd3);
    step(0, 1, 2'b01, 64'h8000, 3'd0, 1, 2, 2);
    chk("flush_top", ras_top_o, 64'h6004);
    chk("flush_tos", 64'(ras_tos_o), 64'd2);
    chk("flush_cnt", 64'(ras_cnt_o), 64'd2);
    step(0, 0, 2'b00, 64'h0, 3'd0, 1, 5, 31);
    chk("flush_sat", 64'(ras_cnt_o), 64'd16);
    // reset dominates flush and ctl
    step(1, 1, 2'b01, 64'h9000, 3'd4, 1, 7, 9);
    chk("rst_top", ras_top_o, 64'h0);
    chk("rst_cnt", 64'(ras_cnt_o), 64'd0);
    chk("rst_tos", 64'(ras_tos_o), 64'd0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      automatic int sel = $urandom_range(0, 99);
      step(sel == 0, $urandom_range(0, 9) != 0, 2'($urandom), {$urandom, $urandom},
           3'($urandom), sel >= 95, $urandom_range(0, 15), $urandom_range(0, 31));
    end
    #1 check_all();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
